// File: rtl/sample_interpolator.sv
// ---------------------------------------------------------------------------
// sample_interpolator
//
// Linear sample-rate upconverter that feeds a delta-sigma modulator. Input
// PCM samples (unsigned, offset-binary) enter through a small FIFO. A phase
// counter runs once per clk. Each time the phase wraps, the next sample is
// popped. Between pops the output ramps linearly from the previous sample to
// the current one, one step per clk.
//
// Parameters
//   DATA_SIZE : sample width in bits
//   OSR_LOG2  : log2 of output clocks per input sample
//   FIFO_LOG2 : log2 of input FIFO depth
//
// Ports
//   clk            : single clock, all logic on posedge
//   reset          : asynchronous, active-high reset
//   in_data        : input sample
//   in_valid       : in_data is valid
//   in_ready       : FIFO can accept a sample (combinational from level)
//   data           : interpolated sample, registered, one per clk
//   sample_tick    : one-cycle pulse on every FIFO pop attempt (phase wrap)
//   underrun       : sticky flag, a pop was attempted on an empty FIFO
//   clear_underrun : synchronous clear of underrun (a new underrun wins)
//   fifo_level     : current FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sample_interpolator #(
    parameter int DATA_SIZE = 32,
    parameter int OSR_LOG2  = 6,
    parameter int FIFO_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_SIZE-1:0] data,
    output logic                 sample_tick,
    output logic                 underrun,
    input  logic                 clear_underrun,
    output logic [FIFO_LOG2:0]   fifo_level
);

    localparam int DEPTH = 1 << FIFO_LOG2;

    localparam logic [DATA_SIZE-1:0] MIDSCALE   = {1'b1, {(DATA_SIZE-1){1'b0}}};
    localparam logic [OSR_LOG2-1:0]  PHASE_ZERO = OSR_LOG2'(0);
    localparam logic [OSR_LOG2-1:0]  PHASE_ONE  = OSR_LOG2'(1);
    localparam logic [OSR_LOG2-1:0]  PHASE_LAST = {OSR_LOG2{1'b1}};
    localparam logic [FIFO_LOG2:0]   LEVEL_ZERO = (FIFO_LOG2+1)'(0);
    localparam logic [FIFO_LOG2:0]   LEVEL_ONE  = (FIFO_LOG2+1)'(1);
    localparam logic [FIFO_LOG2:0]   LEVEL_FULL = (FIFO_LOG2+1)'(DEPTH);
    localparam logic [FIFO_LOG2-1:0] PTR_ZERO   = FIFO_LOG2'(0);
    localparam logic [FIFO_LOG2-1:0] PTR_ONE    = FIFO_LOG2'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Registered state
    state_t                 state_r;
    logic [OSR_LOG2-1:0]    phase_r;
    logic [DATA_SIZE-1:0]   prev_r;
    logic [DATA_SIZE-1:0]   cur_r;
    logic [DATA_SIZE-1:0]   data_r;
    logic                   tick_r;
    logic                   underrun_r;
    logic [FIFO_LOG2:0]     level_r;
    logic [FIFO_LOG2-1:0]   wr_ptr_r;
    logic [FIFO_LOG2-1:0]   rd_ptr_r;
    logic [DATA_SIZE-1:0]   mem_r [DEPTH];

    // Next-state values
    state_t                 state_s;
    logic [OSR_LOG2-1:0]    phase_s;
    logic [DATA_SIZE-1:0]   prev_s;
    logic [DATA_SIZE-1:0]   cur_s;
    logic [DATA_SIZE-1:0]   data_s;
    logic                   tick_s;
    logic                   underrun_s;
    logic [FIFO_LOG2:0]     level_s;
    logic [FIFO_LOG2-1:0]   wr_ptr_s;
    logic [FIFO_LOG2-1:0]   rd_ptr_s;

    // FIFO handshakes
    logic                   empty_s;
    logic                   full_s;
    logic                   push_s;
    logic                   pop_s;
    logic [DATA_SIZE-1:0]   head_s;

    // Interpolation datapath
    logic signed [DATA_SIZE:0]          diff_s;
    logic signed [DATA_SIZE+OSR_LOG2:0] diff_ext_s;
    logic signed [DATA_SIZE+OSR_LOG2:0] phase_ext_s;
    logic signed [DATA_SIZE+OSR_LOG2:0] prod_s;
    logic signed [DATA_SIZE+OSR_LOG2:0] quot_s;
    logic [DATA_SIZE-1:0]               interp_s;
    logic                               unused_quot_s;

    assign in_ready    = !full_s;
    assign data        = data_r;
    assign sample_tick = tick_r;
    assign underrun    = underrun_r;
    assign fifo_level  = level_r;

    // FIFO status from the registered level only, so a push can never be
    // popped in the same cycle it arrives.
    always_comb begin
        empty_s = (level_r == LEVEL_ZERO);
        full_s  = (level_r == LEVEL_FULL);
        push_s  = in_valid && (level_r != LEVEL_FULL);
        head_s  = mem_r[rd_ptr_r];
    end

    // prev + floor((cur - prev) * phase / OSR); the arithmetic right shift
    // of the signed product gives floor toward minus infinity. The sum
    // always lies between prev and cur, so truncating to DATA_SIZE bits
    // is exact.
    always_comb begin
        diff_s      = $signed({1'b0, cur_r}) - $signed({1'b0, prev_r});
        diff_ext_s  = {{OSR_LOG2{diff_s[DATA_SIZE]}}, diff_s};
        phase_ext_s = $signed({{(DATA_SIZE+1){1'b0}}, phase_r});
        prod_s      = diff_ext_s * phase_ext_s;
        quot_s      = prod_s >>> OSR_LOG2;
        interp_s    = prev_r + quot_s[DATA_SIZE-1:0];
    end

    // Upper quotient bits are redundant sign copies of an in-range result.
    assign unused_quot_s = ^quot_s[DATA_SIZE+OSR_LOG2:DATA_SIZE];

    // Sequencer next-state: IDLE waits for the first sample; RUN steps the
    // phase, interpolates, and pops (or flags underrun) on each wrap.
    always_comb begin
        state_s = state_r;
        phase_s = phase_r;
        prev_s  = prev_r;
        cur_s   = cur_r;
        data_s  = data_r;
        pop_s   = 1'b0;
        if (clear_underrun) begin
            underrun_s = 1'b0;
        end else begin
            underrun_s = underrun_r;
        end

        case (state_r)
            IDLE: begin
                phase_s = PHASE_ZERO;
                data_s  = MIDSCALE;
                if (!empty_s) begin
                    state_s = RUN;
                    pop_s   = 1'b1;
                    prev_s  = MIDSCALE;
                    cur_s   = head_s;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                phase_s = phase_r + PHASE_ONE;
                data_s  = interp_s;
                if (phase_r == PHASE_LAST) begin
                    prev_s = cur_r;
                    if (!empty_s) begin
                        cur_s = head_s;
                        pop_s = 1'b1;
                    end else begin
                        // Output holds flat at cur; the set beats any clear.
                        underrun_s = 1'b1;
                    end
                end else begin
                    prev_s = prev_r;
                end
            end
            default: begin
                state_s = IDLE;
                phase_s = PHASE_ZERO;
                prev_s  = MIDSCALE;
                cur_s   = MIDSCALE;
                data_s  = MIDSCALE;
            end
        endcase

        // Registered so sample_tick is high exactly during the wrap cycle.
        tick_s = (state_s == RUN) && (phase_s == PHASE_LAST);
    end

    // FIFO pointer and occupancy next-state; the level is kept apart from
    // the pointers so full and empty are distinguishable.
    always_comb begin
        if (push_s) begin
            wr_ptr_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   level_s = level_r + LEVEL_ONE;
            2'b01:   level_s = level_r - LEVEL_ONE;
            default: level_s = level_r;
        endcase
    end

    // State, datapath and FIFO control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            phase_r    <= PHASE_ZERO;
            prev_r     <= MIDSCALE;
            cur_r      <= MIDSCALE;
            data_r     <= MIDSCALE;
            tick_r     <= 1'b0;
            underrun_r <= 1'b0;
            level_r    <= LEVEL_ZERO;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
        end else begin
            state_r    <= state_s;
            phase_r    <= phase_s;
            prev_r     <= prev_s;
            cur_r      <= cur_s;
            data_r     <= data_s;
            tick_r     <= tick_s;
            underrun_r <= underrun_s;
            level_r    <= level_s;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
        end
    end

    // FIFO storage; cleared on reset so stale samples never reappear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_SIZE{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_sample_interpolator.sv
// ---------------------------------------------------------------------------
// Directed testbench for sample_interpolator (DATA_SIZE=8, OSR_LOG2=2,
// FIFO_LOG2=2, midscale 128). Inputs change and outputs are sampled 1 time
// unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_sample_interpolator;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data;
    logic       sample_tick;
    logic       underrun;
    logic       clear_underrun;
    logic [2:0] fifo_level;

    int checks;
    int errors;

    sample_interpolator #(
        .DATA_SIZE (8),
        .OSR_LOG2  (2),
        .FIFO_LOG2 (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data           (data),
        .sample_tick    (sample_tick),
        .underrun       (underrun),
        .clear_underrun (clear_underrun),
        .fifo_level     (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_data        = 8'd0;
        clear_underrun = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (data !== 8'd128) begin
            errors++;
            $display("FAIL reset_data: got %0d expected 128", data);
        end
        checks++;
        if (fifo_level !== 3'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo: level %0d ready %0b expected 0 1", fifo_level, in_ready);
        end
        checks++;
        if (sample_tick !== 1'b0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: tick %0b underrun %0b expected 0 0", sample_tick, underrun);
        end
        // Idle with nothing pushed: output stays at midscale, no ticks.
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (data !== 8'd128 || sample_tick !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold[%0d]: data %0d tick %0b expected 128 0", i, data, sample_tick);
            end
        end
    endtask

    task automatic test_ramp();
        logic [7:0] exp_data [8];
        logic       exp_tick [8];
        exp_data = '{8'd128, 8'd146, 8'd164, 8'd182, 8'd200, 8'd200, 8'd200, 8'd200};
        exp_tick = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        in_valid = 1'b1;
        in_data  = 8'd200;
        step();
        checks++;
        if (fifo_level !== 3'd1 || data !== 8'd128) begin
            errors++;
            $display("FAIL ramp_first_push: level %0d data %0d expected 1 128", fifo_level, data);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL ramp_push_pop_level: got %0d expected 1", fifo_level);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (data !== exp_data[k] || sample_tick !== exp_tick[k]) begin
                errors++;
                $display("FAIL ramp[%0d]: data %0d tick %0b expected %0d %0b",
                         k, data, sample_tick, exp_data[k], exp_tick[k]);
            end
        end
        checks++;
        if (underrun !== 1'b1 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL ramp_end: underrun %0b level %0d expected 1 0", underrun, fifo_level);
        end
    endtask

    task automatic test_negative_slope();
        logic [7:0] exp_data [8];
        exp_data = '{8'd128, 8'd146, 8'd164, 8'd182, 8'd201, 8'd175, 8'd150, 8'd125};
        apply_reset();
        in_valid = 1'b1;
        in_data  = 8'd201;
        step();
        in_data  = 8'd100;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (data !== exp_data[k]) begin
                errors++;
                $display("FAIL neg_slope[%0d]: got %0d expected %0d", k, data, exp_data[k]);
            end
        end
    endtask

    task automatic test_underrun();
        logic [7:0] exp_data [8];
        logic       exp_u;
        bit         found;
        exp_data = '{8'd128, 8'd146, 8'd164, 8'd182, 8'd200, 8'd200, 8'd200, 8'd200};
        apply_reset();
        in_valid = 1'b1;
        in_data  = 8'd200;
        step();
        in_valid = 1'b0;
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            exp_u = (k >= 3);
            checks++;
            if (data !== exp_data[k] || underrun !== exp_u) begin
                errors++;
                $display("FAIL underrun_seq[%0d]: data %0d underrun %0b expected %0d %0b",
                         k, data, underrun, exp_data[k], exp_u);
            end
        end
        // Clear on a non-wrap cycle takes effect.
        clear_underrun = 1'b1;
        step();
        clear_underrun = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clear: got %0b expected 0", underrun);
        end
        // Line up with the next wrap cycle, then clear while a new underrun hits.
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (sample_tick === 1'b1) begin
                found = 1'b1;
            end else begin
                step();
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL underrun_tick_wait: got no tick expected tick within 8 cycles");
        end
        clear_underrun = 1'b1;
        step();
        clear_underrun = 1'b0;
        checks++;
        if (underrun !== 1'b1 || data !== 8'd200) begin
            errors++;
            $display("FAIL underrun_set_wins: underrun %0b data %0d expected 1 200", underrun, data);
        end
    endtask

    task automatic test_full_fifo();
        logic [7:0] vals [6];
        logic [2:0] exp_lvl [7];
        logic       exp_rdy [7];
        logic [7:0] exp_out [7];
        int         idx;
        logic       rdy_before;
        vals    = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
        exp_lvl = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_out = '{8'd128, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
        apply_reset();
        idx      = 0;
        in_valid = 1'b1;
        in_data  = vals[0];
        for (int c = 0; c <= 26; c++) begin
            rdy_before = in_ready;
            step();
            if (in_valid && rdy_before) begin
                idx++;
                if (idx >= 6) begin
                    in_valid = 1'b0;
                end else begin
                    in_data = vals[idx];
                end
            end
            if (c <= 6) begin
                checks++;
                if (fifo_level !== exp_lvl[c] || in_ready !== exp_rdy[c]) begin
                    errors++;
                    $display("FAIL full_level[%0d]: level %0d ready %0b expected %0d %0b",
                             c, fifo_level, in_ready, exp_lvl[c], exp_rdy[c]);
                end
            end
            if (c >= 2 && ((c - 2) % 4) == 0) begin
                checks++;
                if (data !== exp_out[(c-2)/4]) begin
                    errors++;
                    $display("FAIL full_order[%0d]: got %0d expected %0d", c, data, exp_out[(c-2)/4]);
                end
            end
        end
        checks++;
        if (fifo_level !== 3'd0 || underrun !== 1'b1 || idx !== 6) begin
            errors++;
            $display("FAIL full_end: level %0d underrun %0b accepted %0d expected 0 1 6",
                     fifo_level, underrun, idx);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] vals [4];
        vals = '{8'd10, 8'd20, 8'd30, 8'd40};
        apply_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = vals[i];
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd3 || data !== 8'd98) begin
            errors++;
            $display("FAIL midrun_pre: level %0d data %0d expected 3 98", fifo_level, data);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (data !== 8'd128 || fifo_level !== 3'd0 || in_ready !== 1'b1 || sample_tick !== 1'b0) begin
            errors++;
            $display("FAIL midrun_async: data %0d level %0d ready %0b tick %0b expected 128 0 1 0",
                     data, fifo_level, in_ready, sample_tick);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (sample_tick !== 1'b0 || data !== 8'd128 || fifo_level !== 3'd0) begin
                errors++;
                $display("FAIL midrun_idle[%0d]: tick %0b data %0d level %0d expected 0 128 0",
                         i, sample_tick, data, fifo_level);
            end
        end
        // A fresh push restarts the ramp from midscale.
        in_valid = 1'b1;
        in_data  = 8'd64;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        checks++;
        if (data !== 8'd112) begin
            errors++;
            $display("FAIL midrun_restart: got %0d expected 112", data);
        end
        step();
        checks++;
        if (sample_tick !== 1'b1) begin
            errors++;
            $display("FAIL midrun_restart_tick: got %0b expected 1", sample_tick);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ramp();
        test_negative_slope();
        test_underrun();
        test_full_fifo();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_interpolator.md
SAMPLE_INTERPOLATOR -- requirements
Module: sample_interpolator

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, sample width in bits (unsigned, offset-binary PCM).
REQ-002 SHALL have parameter OSR_LOG2, default 6, log2 of output cycles per input sample (OSR = 2^OSR_LOG2).
REQ-003 SHALL have parameter FIFO_LOG2, default 2, log2 of input FIFO depth (DEPTH = 2^FIFO_LOG2).
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_data  input  DATA_SIZE  input sample.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept a sample.
REQ-009 SHALL have port data  output  DATA_SIZE  interpolated sample; drives the delta-sigma modulator data input every clk.
REQ-010 SHALL have port sample_tick  output  1  one-cycle pulse on each FIFO pop attempt (phase wrap).
REQ-011 SHALL have port underrun  output  1  sticky flag: pop attempted on empty FIFO.
REQ-012 SHALL have port clear_underrun  input  1  synchronous clear of underrun.
REQ-013 SHALL have port fifo_level  output  FIFO_LOG2+1  current FIFO occupancy, 0..DEPTH.

Function
REQ-014 SHALL accept a sample into the FIFO on any clk edge where in_valid && in_ready; in_ready = (fifo_level != DEPTH), combinational from the level.
REQ-015 SHALL implement states IDLE and RUN; IDLE -> RUN on first cycle fifo_level != 0, popping head into cur, loading prev = midscale (2^(DATA_SIZE-1)), phase = 0; RUN is exited only by reset.
REQ-016 SHALL hold data = midscale, phase = 0, sample_tick = 0 while in IDLE.
REQ-017 In RUN, SHALL increment an OSR_LOG2-bit phase counter every clk, wrapping from OSR-1 to 0.
REQ-018 On the cycle phase = OSR-1 in RUN, SHALL pulse sample_tick and, if FIFO non-empty, load prev = cur, cur = FIFO head, and pop.
REQ-019 On that cycle with FIFO empty, SHALL set underrun, load prev = cur, leave cur unchanged (output holds flat at cur), and pop nothing.
REQ-020 A push into an empty FIFO on the same cycle as a pop attempt SHALL NOT bypass: pop sees empty (underrun); the pushed sample is stored.
REQ-021 Simultaneous push and pop on a non-full FIFO SHALL leave fifo_level unchanged; push when full is impossible (in_ready = 0).
REQ-022 SHALL register data each RUN cycle as prev + floor(((cur - prev) * phase) / OSR), using current-cycle prev, cur, phase; latency 1 clk.
REQ-023 Difference SHALL be signed DATA_SIZE+1 bits, product DATA_SIZE+1+OSR_LOG2 bits, division as arithmetic right shift by OSR_LOG2 (floor toward minus infinity); result lies within [min(prev,cur), max(prev,cur)], so no overflow or saturation occurs.
REQ-024 FIFO read/write pointers SHALL wrap modulo DEPTH, with occupancy tracked separately so full and empty are distinguished.
REQ-025 If clear_underrun and a new underrun occur on the same cycle, underrun SHALL be 1 (set wins).

Reset
REQ-026 While reset is high (asynchronous): state = IDLE, FIFO empty, fifo_level = 0, in_ready = 1, data = midscale, prev = cur = midscale, phase = 0, sample_tick = 0, underrun = 0.
REQ-027 Reset asserted mid-RUN SHALL discard FIFO contents immediately; on release the block waits in IDLE for a new sample.

Verification (DATA_SIZE=8, OSR_LOG2=2, FIFO_LOG2=2; midscale 128)
REQ-028 Ramp-up: push 200 then 200 after reset -> data sequence 128,146,164,182, then 200 constant; sample_tick every 4th cycle in RUN.
REQ-029 Negative slope with floor: prev = 201, cur = 100 -> data 201,175,150,125 (phase 1 offset -101/4 floors to -26).
REQ-030 Underrun: push single sample 200, no more -> after ramp data holds 200, underrun = 1 at first empty pop; clear_underrun -> 0; clear with concurrent underrun -> stays 1.
REQ-031 Full FIFO: push 6 samples back-to-back with in_valid held high -> in_ready drops when fifo_level = 4, no sample lost or duplicated, output follows samples in order.
REQ-032 Reset mid-RUN with fifo_level = 3 -> data = 128, fifo_level = 0, in_ready = 1 immediately, no sample_tick until a new push.
